// File: rtl/fp4_prod_accum.sv
// FP4 product accumulator: decodes product words into fixed-point terms
// and sums them into a saturated dot-product result for the activation engine.
module fp4_prod_accum #(
    parameter int LEN   = 16,
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [5:0]         in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_data,
    output logic               out_sat,
    output logic [CNT_W:0]     out_count
);

    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic signed [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] S_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                  state, state_nx;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] mag_x;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W:0]   sum_w;
    logic [5:0]              mag;
    logic [CNT_W-1:0]        cnt;
    logic                    sat_flag;
    logic                    sat_now;
    logic                    accept;
    logic                    final_acc;

    // Term magnitude is in units of 2^-3; exp==0 encodes zero for either sign.
    always_comb begin
        mag = '0;
        if (in_data[4:3] != 2'b00)
            mag = {3'b001, in_data[2:0]} << (in_data[4:3] - 2'd1);
        mag_x = {{(ACC_W-6){1'b0}}, mag};
        term  = in_data[5] ? -mag_x : mag_x;
    end

    always_comb begin
        sum_w   = {acc[ACC_W-1], acc} + {term[ACC_W-1], term};
        sat_now = sum_w[ACC_W] != sum_w[ACC_W-1];
        sum     = sum_w[ACC_W-1:0];
        if (sat_now)
            sum = sum_w[ACC_W] ? S_MIN : S_MAX;
    end

    assign in_ready  = (state == ACCUM) || clear;
    assign accept    = in_valid && (state == ACCUM) && !clear;
    assign final_acc = in_last || (cnt == CNT_W'(LEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ACCUM;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ACCUM: if (accept && final_acc) state_nx = HOLD;
            HOLD:  if (out_ready)           state_nx = ACCUM;
            default:                        state_nx = ACCUM;
        endcase
        if (clear)
            state_nx = ACCUM;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            sat_flag  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_count <= '0;
        end else if (clear) begin
            acc       <= '0;
            cnt       <= '0;
            sat_flag  <= 1'b0;
            out_valid <= 1'b0;
        end else if (accept) begin
            if (final_acc) begin
                out_data  <= sum;
                out_sat   <= sat_flag | sat_now;
                out_count <= {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
                out_valid <= 1'b1;
                acc       <= '0;
                cnt       <= '0;
                sat_flag  <= 1'b0;
            end else begin
                acc      <= sum;
                cnt      <= cnt + CNT_W'(1);
                sat_flag <= sat_flag | sat_now;
            end
        end else if (state == HOLD && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fp4_prod_accum.sv
// Randomised bench for fp4_prod_accum: two instances (16-bit and 8-bit
// accumulators) share one stimulus stream and are scored against a reference model.
module tb_fp4_prod_accum;

    localparam int LEN = 16;
    localparam int WID [2] = '{16, 8};

    logic       clk = 1'b0;
    logic       rst, clear, in_valid, in_last, out_ready;
    logic [5:0] in_data;
    logic       in_ready_a, in_ready_b, out_valid_a, out_valid_b;
    logic       out_sat_a, out_sat_b;
    logic [15:0] out_data_a;
    logic [7:0]  out_data_b;
    logic [8:0]  out_count_a, out_count_b;

    int checks = 0;
    int errors = 0;

    int m_acc [2];
    int m_sat [2];
    int m_cnt;
    int e_data [2];
    int e_sat [2];
    int e_cnt;

    always #5 clk = ~clk;

    fp4_prod_accum #(.LEN(LEN), .ACC_W(16), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_sat(out_sat_a),
        .out_count(out_count_a)
    );

    fp4_prod_accum #(.LEN(LEN), .ACC_W(8), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_sat(out_sat_b),
        .out_count(out_count_b)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int decode(input logic [5:0] w);
        int e, m, mag;
        e = int'(w[4:3]);
        m = int'(w[2:0]);
        if (e == 0) return 0;
        mag = (8 + m) * (2 ** (e - 1));
        return w[5] ? -mag : mag;
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = 0;
            m_sat[i] = 0;
        end
    endtask

    task automatic model_accept(input logic [5:0] w, input logic l, output bit fin);
        int t, s, hi, lo, sn;
        t   = decode(w);
        fin = l || (m_cnt == LEN - 1);
        for (int i = 0; i < 2; i++) begin
            hi = 2 ** (WID[i] - 1) - 1;
            lo = -(2 ** (WID[i] - 1));
            s  = m_acc[i] + t;
            sn = 0;
            if (s > hi) begin s = hi; sn = 1; end
            if (s < lo) begin s = lo; sn = 1; end
            if (fin) begin
                e_data[i] = s;
                e_sat[i]  = m_sat[i] | sn;
            end else begin
                m_acc[i] = s;
                m_sat[i] = m_sat[i] | sn;
            end
        end
        if (fin) begin
            e_cnt = m_cnt + 1;
            model_reset();
        end else begin
            m_cnt++;
        end
    endtask

    // Called and returns at a falling edge.
    task automatic send(input logic [5:0] w, input logic l, output bit fin);
        int n = 0;
        fin      = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        in_last  = l;
        while (!in_ready_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_a) begin
            check("send_timeout", int'(in_ready_a), 1);
            in_valid = 1'b0;
            return;
        end
        model_accept(w, l, fin);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (fin) begin
            check("lat_a", int'(out_valid_a), 1);
            check("lat_b", int'(out_valid_b), 1);
            check("hold_rdy", int'(in_ready_a), 0);
        end
    endtask

    task automatic take();
        check("vld", int'(out_valid_a), 1);
        check("data_a", int'($signed(out_data_a)), e_data[0]);
        check("data_b", int'($signed(out_data_b)), e_data[1]);
        check("sat_a", int'(out_sat_a), e_sat[0]);
        check("sat_b", int'(out_sat_b), e_sat[1]);
        check("cnt_a", int'(out_count_a), e_cnt);
        check("cnt_b", int'(out_count_b), e_cnt);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("drain", int'(out_valid_a), 0);
        check("rdy_after", int'(in_ready_a), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bit fin;
        int len, j;
        logic [5:0] w;
        logic [5:0] dec_w [4] = '{6'b001000, 6'b011111, 6'b110100, 6'b100101};
        int dec_e [4] = '{8, 60, -24, 0};

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b0; in_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_vld", int'(out_valid_a), 0);
        check("rst_data", int'(out_data_a), 0);
        check("rst_sat", int'(out_sat_a), 0);
        check("rst_cnt", int'(out_count_a), 0);
        check("rst_rdy", int'(in_ready_a), 1);

        for (int i = 0; i < 4; i++) begin
            send(dec_w[i], 1'b1, fin);
            check("dec_const", int'($signed(out_data_a)), dec_e[i]);
            take();
        end

        for (int i = 0; i < 16; i++) send(6'b011111, 1'b0, fin);
        check("full_fin", int'(fin), 1);
        check("full_960", int'($signed(out_data_a)), 960);
        take();

        send(6'b001000, 1'b0, fin);
        send(6'b110100, 1'b0, fin);
        send(6'b011111, 1'b1, fin);
        check("early_44", int'($signed(out_data_a)), 44);
        take();
        send(6'b001000, 1'b1, fin);
        check("fresh_8", int'($signed(out_data_a)), 8);
        take();

        for (int i = 0; i < 3; i++) send(6'b011111, 1'b0, fin);
        send(6'b111111, 1'b0, fin);
        send(6'b111111, 1'b1, fin);
        check("sat_7", int'($signed(out_data_b)), 7);
        check("sat_flag", int'(out_sat_b), 1);
        take();

        send(6'b001000, 1'b1, fin);
        in_valid = 1'b1;
        in_data  = 6'b011111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rdy", int'(in_ready_a), 0);
            check("bp_data", int'($signed(out_data_a)), 8);
            check("bp_vld", int'(out_valid_a), 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("bp_release", int'(in_ready_a), 1);

        for (int i = 0; i < 5; i++) send(6'b011111, 1'b0, fin);
        in_valid = 1'b1;
        in_data  = 6'b011111;
        clear    = 1'b1;
        #1;
        check("clr_rdy", int'(in_ready_a), 1);
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        model_reset();
        send(6'b001000, 1'b0, fin);
        send(6'b001000, 1'b1, fin);
        check("clr_16", int'($signed(out_data_a)), 16);
        check("clr_cnt2", int'(out_count_a), 2);
        take();

        for (int i = 0; i < 3; i++) send(6'b011111, 1'b0, fin);
        #3;
        rst = 1'b1;
        #1;
        check("arst_vld", int'(out_valid_a), 0);
        check("arst_data", int'(out_data_a), 0);
        check("arst_cnt", int'(out_count_a), 0);
        check("arst_sat_b", int'(out_sat_b), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("arst_rdy", int'(in_ready_a), 1);

        for (int v = 0; v < 40; v++) begin
            len = $urandom_range(1, 20);
            j   = 0;
            fin = 1'b0;
            while (!fin) begin
                w = 6'($urandom);
                repeat ($urandom_range(0, 1)) @(negedge clk);
                send(w, (j == len - 1), fin);
                j++;
                if (j > 40) break;
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            take();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp4_prod_accum.md
Name: fp4_prod_accum

Overview:
- Accumulator stage directly downstream of the FP4 multiplier.
- Consumes 6-bit FP4 product words {sign, exp[1:0], mant[2:0]} one per cycle over a valid/ready handshake.
- Decodes each word to a signed fixed-point term and sums a vector of up to LEN terms, or fewer when in_last is asserted.
- Presents the saturated dot-product result on a valid/ready output port to the activation engine.

Parameters:
- LEN, 16: terms per dot product when in_last is not asserted; range 2..256.
- ACC_W, 16: accumulator/result width, two's complement signed; range 8..32.
- CNT_W, 8: term counter width; must satisfy 2^CNT_W >= LEN.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous flush; abandons the current vector.
- in_valid  input  1  product word valid.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  6  FP4 product {sign, exp[1:0], mant[2:0]}.
- in_last  input  1  word is the final term of the vector; sampled only on accept.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  ACC_W  signed dot-product result.
- out_sat  output  1  saturation occurred in this result; valid with out_valid.
- out_count  output  CNT_W+1  number of terms in this result.

Behaviour:
- Reset (async, any state): state=ACCUM, acc=0, cnt=0, sat_flag=0, out_valid=0, out_data=0, out_sat=0, out_count=0. in_ready is therefore 1 on the first cycle after reset release.
- Decode (combinational on in_data):
  - exp==0 gives term 0 (sign ignored, so -0 = 0).
  - Otherwise mag = (8+mant) << (exp-1), range 8..60 in units of 2^-3.
  - term = sign ? -mag : mag, sign-extended to ACC_W.
- Accept: in_valid && in_ready.
- States:
  - ACCUM: in_ready=1, out_valid=0. On accept, sum = acc + term, saturated to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Saturation sets sat_flag; sat_flag is sticky for the vector.
  - ACCUM, non-final accept: acc<=sum, cnt<=cnt+1.
  - ACCUM, final accept (in_last=1 or cnt==LEN-1): out_data<=sum, out_sat<=sat_flag|sat_now, out_count<=cnt+1, out_valid<=1. Then acc, cnt and sat_flag are cleared and state goes to HOLD.
  - HOLD: in_ready=0. out_data, out_sat and out_count stay stable while out_valid=1. When out_ready=1, out_valid<=0 and state goes to ACCUM.
- Latency and throughput:
  - Result is valid the cycle after the final accept.
  - Sustained one term per cycle within a vector.
  - Minimum one HOLD cycle between vectors.
- Saturation clamps every step. Once clamped, subsequent terms add to the clamped value (no wrap).
- clear (highest priority after rst), in any state: acc=0, cnt=0, sat_flag=0, out_valid=0, state goes to ACCUM. An accept in the same cycle is discarded. out_data, out_sat and out_count retain their last values.
- Simultaneous in_valid and clear: the word is dropped, and upstream sees in_ready=1. Upstream must not rely on data accepted under clear.
- Reset mid-vector: the partial sum is lost and no output is produced.
- in_data and in_last are don't-care when in_valid=0. The counter never exceeds LEN-1 in ACCUM.

Test Plan:
- Decode sweep, LEN=2, in_last=1 on each word:
  - 0_01_000 gives out_data=+8.
  - 0_11_111 gives +60.
  - 1_10_100 gives -24.
  - 1_00_101 gives 0.
  - In all cases out_count=1 and out_sat=0.
- Full vector, LEN=16, ACC_W=16: 16 back-to-back words of 0_11_111 give out_valid exactly one cycle after the 16th accept, out_data=960, out_count=16, out_sat=0. in_ready=0 during HOLD.
- Early termination: terms +8, -24, +60, with in_last on the third, give out_data=44 and out_count=3. The next vector starts with acc=0.
- Saturation, ACC_W=8: 3×(+60) gives out_data=127 and out_sat=1. Then 2×(-60) with in_last gives 7, because the clamp is held rather than wrapped, and out_sat=1.
- Backpressure: hold out_ready=0 for 5 cycles after a result with in_valid=1. Required: out_data stable, in_ready=0, no words consumed. out_ready=1 then gives in_ready=1 the next cycle.
- Clear and reset:
  - clear after 5 accepts, then a fresh 2-term vector of +8 and +8, gives out_data=16 and out_count=2.
  - Async rst asserted mid-vector gives all outputs 0 immediately and in_ready=1 after release.
